// File: rtl/mul_div_seq_if.sv
// Request / write-back bundle between the register bank and mul_div_seq.
//   start, op, src1, src2, rd : request side (driven by the issuing master)
//   busy, done, we, a3, wd3   : status and bank write-port side (driven by the unit)
interface mul_div_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;

  modport master (
    output start, op, src1, src2, rd,
    input  busy, done, we, a3, wd3
  );

  modport slave (
    input  start, op, src1, src2, rd,
    output busy, done, we, a3, wd3
  );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// Latches operands on start, iterates XLEN cycles, then issues one
// write-back cycle to the register bank.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of mul_div_seq_if (request in, status/write-back out)
module mul_div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WB} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [4:0]      r_rd;
  logic [4:0]      r_a3;
  logic [XLEN-1:0] r_wd3;

  logic            w_div0;
  logic            w_last;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  assign w_div0 = bus.op[1] && (bus.src2 == '0);
  assign w_last = (r_cnt == CW'(XLEN - 1));

  // r_hi/r_lo are shared: {hi,lo} is the product accumulator for multiply,
  // and partial remainder / dividend-becoming-quotient for divide.
  // Multiply: add to the high half, then shift the whole pair right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: shift in next dividend bit to form the XLEN+1-bit trial remainder.
  assign w_shift   = {r_hi, r_lo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  // When w_ge holds the true difference fits in XLEN bits.
  assign w_diff    = w_shift[XLEN-1:0] - r_b;

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op[1]) begin
      w_hi_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = w_div0 ? S_WB : S_CALC;
      S_CALC:  if (w_last)    w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_rd  <= '0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op;
            r_b   <= bus.src2;
            r_rd  <= bus.rd;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= bus.src1;
            if (w_div0) begin
              r_wd3 <= bus.op[0] ? bus.src1 : '1;
              r_a3  <= bus.rd;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // High half holds MULHU result / remainder; low half MUL / quotient.
            r_wd3 <= r_op[0] ? w_hi_nxt : w_lo_nxt;
            r_a3  <= r_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_WB);
  assign bus.we   = (r_state == S_WB) && (r_a3 != '0);
  assign bus.a3   = r_a3;
  assign bus.wd3  = r_wd3;

endmodule

// File: tb/tb_mul_div_seq.sv
module tb_mul_div_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mul_div_seq_if #(.XLEN(32)) bus ();

  mul_div_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to write-back. exp_lat counts edges after E0.
  // With poke set, a DIVU 9/3 start is pulsed 10 cycles into the op.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_wd,
                        input int exp_lat, input bit poke);
    int n;
    logic we_early;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src1  = a;
    bus.src2  = b;
    bus.rd    = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({name, " busy_after_E0"}, 32'(bus.busy), 32'd1);
    n = 0;
    we_early = 1'b0;
    while (!bus.done && n < 40) begin
      if (poke && n == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.src1  = 32'd9;
        bus.src2  = 32'd3;
        bus.rd    = 5'd7;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.we && !bus.done) we_early = 1'b1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " done"}, 32'(bus.done), 32'd1);
    check({name, " early_we"}, 32'(we_early), 32'd0);
    check({name, " we"}, 32'(bus.we), (rd != 5'd0) ? 32'd1 : 32'd0);
    check({name, " a3"}, 32'(bus.a3), 32'(rd));
    check({name, " wd3"}, bus.wd3, exp_wd);
    @(posedge clk); #1;
    check({name, " busy_after"}, 32'(bus.busy), 32'd0);
    check({name, " done_after"}, 32'(bus.done), 32'd0);
    check({name, " wd3_hold"}, bus.wd3, exp_wd);
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_fail   = 0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.rd    = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst we",   32'(bus.we),   32'd0);
    check("rst a3",   32'(bus.a3),   32'd0);
    check("rst wd3",  bus.wd3,       32'd0);

    run_op("mul7x6",    2'b00, 32'd7,          32'd6,          5'd5, 32'h0000002A, 32, 1'b0);
    run_op("mulhu_ff",  2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd3, 32'hFFFFFFFE, 32, 1'b0);
    run_op("mul_ff",    2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd3, 32'h00000001, 32, 1'b0);
    run_op("mul_x9",    2'b00, 32'h12345678,   32'd9,          5'd4, 32'hA3D70A38, 32, 1'b0);
    run_op("divu100_7", 2'b10, 32'd100,        32'd7,          5'd9, 32'd14,       32, 1'b0);
    run_op("remu100_7", 2'b11, 32'd100,        32'd7,          5'd9, 32'd2,        32, 1'b0);
    run_op("divu_big",  2'b10, 32'hDEADBEEF,   32'h10,         5'd31, 32'h0DEADBEE, 32, 1'b0);
    run_op("remu_big",  2'b11, 32'hDEADBEEF,   32'h10,         5'd30, 32'h0000000F, 32, 1'b0);
    run_op("divu_by0",  2'b10, 32'd5,          32'd0,          5'd6, 32'hFFFFFFFF, 0,  1'b0);
    run_op("remu_by0",  2'b11, 32'd5,          32'd0,          5'd6, 32'd5,        0,  1'b0);
    run_op("mul_poke",  2'b00, 32'd7,          32'd6,          5'd5, 32'h0000002A, 32, 1'b1);
    run_op("mul_rd0",   2'b00, 32'd7,          32'd6,          5'd0, 32'h0000002A, 32, 1'b0);

    // Abort: reset 10 cycles into a MUL.
    run_op("mul_pre",   2'b00, 32'd3,          32'd5,          5'd8, 32'd15,       32, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.src1  = 32'd7;
    bus.src2  = 32'd6;
    bus.rd    = 5'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort a3",   32'(bus.a3),   32'd0);
    check("abort wd3",  bus.wd3,       32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.we || bus.done || bus.busy) seen++;
    end
    check("abort no_wb", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Iterative unsigned multiply/divide unit for the RV32 datapath. Sits between the register bank's read ports and its write port: it latches two operands read from the bank (`rd1`/`rd2` values), computes over 32 cycles, then issues a single-cycle write-back request (`we`, `a3`, `wd3`) that drives the bank's write port directly. The unit handles the long-latency M-extension unsigned ops that the single-cycle ALU cannot.

## Interface
- `XLEN`, 32, operand/result width; the iteration count equals `XLEN`.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- `src1`  in  XLEN  operand 1 / dividend (from bank `rd1`).
- `src2`  in  XLEN  operand 2 / divisor (from bank `rd2`).
- `rd`  in  5  destination register index.
- `busy`  out  1  high in CALC and WB.
- `done`  out  1  one-cycle pulse in WB.
- `we`  out  1  write enable to bank; high in WB only when latched `rd != 0`.
- `a3`  out  5  write address to bank (latched `rd`).
- `wd3`  out  XLEN  write data to bank (result register).

## Operation
- States: IDLE, CALC, WB.
- IDLE: when `start`=1 at an edge, latch `op`, `src1`, `src2`, `rd`, clear the iteration counter, and go to CALC. The only exception: a divide (`op[1]`=1) with `src2`=0 loads its result immediately and goes to WB.
- CALC: performs one iteration per edge. After the 32nd iteration, load the result register and go to WB.
  - Multiply is shift-add with a 2·XLEN-bit accumulator. MUL takes bits [31:0]; MULHU takes bits [63:32].
  - Divide is restoring division with an XLEN+1-bit partial remainder. DIVU gives the quotient; REMU gives the remainder.
- WB: `done`=1 for one cycle. `we`=1 if latched `rd != 0`. Next state is always IDLE.
- Divide by zero: DIVU result is 0xFFFFFFFF; REMU result is `src1` (RISC-V semantics). No trap.
- `start` in CALC or WB is ignored. It is not queued, and the latched operands are unaffected.
- All arithmetic is unsigned and modulo 2^XLEN on outputs. No overflow flag.
- `reset`:
  - Takes priority over everything and applies from any state.
  - Sets state IDLE; `busy`, `done`, and `we` to 0; `a3` to 0; `wd3` to 0; counter to 0.
  - Reset mid-operation aborts the operation with no write-back.

## Timing
- Every output comes from a register or is decoded from the state register only. There is no combinational path from inputs to outputs.
- Let edge E0 be the edge that samples `start`=1 in IDLE.
- Normal op:
  - `busy`=1 from after E0.
  - Iterations occur at edges E1..E32.
  - The WB cycle runs from after E32 to E33.
  - The bank captures `wd3` at E33.
  - IDLE with `busy`=0 after E33.
- Latency is 32 cycles from start-sample to `done`; occupancy is 33 cycles.
- Divide by zero: WB from after E0; IDLE after E1.
- Back-to-back: `start` held high continuously is sampled again at the first edge in IDLE, i.e. E34 for a normal op.
- `a3` and `wd3` remain stable from WB until the next WB or reset. Only `we` qualifies them.

## Test plan
- Reset held for 2 cycles, then released → `busy`=`done`=`we`=0, `a3`=0, `wd3`=0.
- MUL, `src1`=7, `src2`=6, `rd`=5 → at cycle 32: `done`=1, `we`=1, `a3`=5, `wd3`=0x0000002A. After that: `busy`=0.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF, `rd`=3 → `wd3`=0xFFFFFFFE at cycle 32. A repeat with MUL gives `wd3`=0x00000001.
- DIVU 100/7 → `wd3`=14. REMU 100/7 → `wd3`=2. DIVU 5/0 → 0xFFFFFFFF with `done` one cycle after start. REMU 5/0 → `wd3`=5.
- Start issued while busy: MUL 7×6 in flight, `start` pulsed with DIVU 9/3 at cycle 10 → only 0x2A is written, at cycle 32.
- Abort and rd=0 cases:
  - `reset` asserted at cycle 10 of a MUL → `busy`=0 at the next cycle, and no `we` ever fires.
  - MUL 7×6 with `rd`=0 → `done` pulses at cycle 32 while `we` stays 0.
